// File: rtl/cache_controller.sv
// cache_controller
// Two-way set-associative, write-through, no-write-allocate data cache that
// sits between the memory stage and the SRAM controller.
//   - Read hits return data combinationally with no stall.
//   - Read misses fetch a 64-bit line (two words) and fill the LRU way.
//   - Every write is forwarded to SRAM. A write that hits also updates the
//     cached word.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset
//   r_en_in, w_en_in     memory-stage read / write request (write has priority)
//   address_in           byte address: [2] word, [8:3] index, [18:9] tag
//   write_data_in        store data
//   read_data_out        load data, valid while ready_out and r_en_in are high
//   ready_out            low freezes the whole pipeline
//   sram_r_en_out        line-read request to the SRAM controller
//   sram_w_en_out        word-write request to the SRAM controller
//   sram_address_out     word address {15'b0, address_in[18:2]}
//   sram_write_data_out  forwarded store data
//   sram_read_data_in    line from SRAM; [31:0] is the even word
//   sram_ready_in        SRAM transaction complete; line data valid this cycle
module cache_controller #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_en_in,
  input  logic        w_en_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  output logic [31:0] read_data_out,
  output logic        ready_out,
  output logic        sram_r_en_out,
  output logic        sram_w_en_out,
  output logic [31:0] sram_address_out,
  output logic [31:0] sram_write_data_out,
  input  logic [63:0] sram_read_data_in,
  input  logic        sram_ready_in
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Address fields
  logic                  word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;

  assign word_sel = address_in[2];
  assign index    = address_in[3 +: INDEX_BITS];
  assign tag      = address_in[3 + INDEX_BITS +: TAG_BITS];

  // Byte offset and upper address bits are not part of the cache lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_in[31:19], address_in[1:0]};

  // Storage. Valid and LRU bits need reset. Tags and data do not, because
  // a way is never consulted unless its valid bit is set.
  logic [1:0][SETS-1:0] valid_reg;
  logic [SETS-1:0]      lru_reg;
  logic [TAG_BITS-1:0]  tag_mem  [2][SETS];
  logic [63:0]          data_mem [2][SETS];

  // Lookup
  logic [1:0]  way_hit;
  logic [31:0] way_word [2];
  logic        hit;
  logic        hit_way;
  logic [31:0] hit_word;
  logic [31:0] line_word;
  logic        victim;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      assign way_hit[gi]  = valid_reg[gi][index] && (tag_mem[gi][index] == tag);
      assign way_word[gi] = word_sel ? data_mem[gi][index][63:32]
                                     : data_mem[gi][index][31:0];
    end
  endgenerate

  // Both ways never hold the same tag, so way1's hit alone identifies the way.
  assign hit       = |way_hit;
  assign hit_way   = way_hit[1];
  assign hit_word  = hit_way ? way_word[1] : way_word[0];
  assign line_word = word_sel ? sram_read_data_in[63:32] : sram_read_data_in[31:0];
  assign victim    = lru_reg[index];

  // Next-state and output decode
  logic        ready_c;
  logic [31:0] read_data_c;
  logic        fill_en;
  logic        update_en;
  logic        touch_en;

  always_comb begin
    state_next  = state_reg;
    ready_c     = 1'b0;
    read_data_c = 32'h0;
    fill_en     = 1'b0;
    update_en   = 1'b0;
    touch_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (w_en_in) begin
          state_next = WRITE;
        end else if (r_en_in) begin
          if (hit) begin
            ready_c     = 1'b1;
            read_data_c = hit_word;
            touch_en    = 1'b1;
          end else begin
            state_next = READ_MISS;
          end
        end else begin
          ready_c = 1'b1;
        end
      end
      READ_MISS: begin
        if (sram_ready_in) begin
          ready_c     = 1'b1;
          read_data_c = line_word;
          fill_en     = 1'b1;
          state_next  = IDLE;
        end
      end
      WRITE: begin
        if (sram_ready_in) begin
          ready_c    = 1'b1;
          update_en  = hit;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The pipeline must see a stall and no data for as long as reset is held,
  // even though the FSM itself sits in IDLE.
  assign ready_out     = rst & ready_c;
  assign read_data_out = rst ? read_data_c : 32'h0;

  // SRAM enables come from the state register alone, so they are glitch-free,
  // mutually exclusive and drop on the edge that completes the transaction.
  assign sram_r_en_out       = (state_reg == READ_MISS);
  assign sram_w_en_out       = (state_reg == WRITE);
  assign sram_address_out    = {15'b0, address_in[18:2]};
  assign sram_write_data_out = write_data_in;

  // State, valid and LRU
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      lru_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (fill_en) begin
        valid_reg[victim][index] <= 1'b1;
        lru_reg[index]           <= ~victim;
      end else if (touch_en || update_en) begin
        // The way just used becomes MRU, so LRU points at the other one.
        lru_reg[index] <= ~hit_way;
      end
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[victim][index]  <= tag;
      data_mem[victim][index] <= sram_read_data_in;
    end
    if (update_en) begin
      if (word_sel) begin
        data_mem[hit_way][index][63:32] <= write_data_in;
      end else begin
        data_mem[hit_way][index][31:0] <= write_data_in;
      end
    end
  end

endmodule
